// File: rtl/system_widths_pkg.sv
// Shared widths for the memory request/response protocol.
// ADDR_W: byte address width; MEM_DATA_W: data byte width.
package system_widths_pkg;

    localparam int ADDR_W     = 16;
    localparam int MEM_DATA_W = 8;

endpackage

// File: rtl/mem_lat_responder_lat_pipe.sv
// lat_pipe: DEPTH-stage valid+data shift register, async active-high clear.
// Ports: clk_i, clr_i, vld_i/dat_i (stage 0 input), vld_o/dat_o (last stage).
module lat_pipe #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         vld_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [W-1:0]     dat_q [DEPTH];
    logic [W-1:0]     dat_d [DEPTH];

    always_comb begin
        vld_d[0] = vld_i;
        dat_d[0] = dat_i;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    // Data only moves with a valid token, so the last stage holds
    // the most recent response data while idle.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_d[i]) begin
                    dat_q[i] <= dat_d[i];
                end
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign dat_o = dat_q[DEPTH-1];

endmodule

// File: rtl/mem_lat_responder.sv
// Fixed-latency in-order memory responder with in-flight throttling.
// Ports: clk, reset, mem_req_* (request), mem_resp_* (response), out_cnt_dbg.
module mem_lat_responder
    import system_widths_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int RD_LAT    = 4,
    parameter int MAX_OUT   = 4,
    localparam int CW       = $clog2(MAX_OUT + 1),
    localparam int IW       = $clog2(MEM_BYTES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_req_valid,
    output logic                  mem_req_ready,
    input  logic                  mem_req_we,
    input  logic [ADDR_W-1:0]     mem_req_addr,
    input  logic [MEM_DATA_W-1:0] mem_req_write,
    output logic                  mem_resp_valid,
    output logic [MEM_DATA_W-1:0] mem_resp_data,
    output logic [CW-1:0]         out_cnt_dbg
);

    logic [MEM_DATA_W-1:0] mem_q [MEM_BYTES];
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [IW-1:0]         idx;
    logic                  acc;
    logic [MEM_DATA_W-1:0] rsp_dat;
    logic                  unused_addr;

    assign idx         = mem_req_addr[IW-1:0];
    assign unused_addr = ^mem_req_addr[ADDR_W-1:IW];
    assign acc         = mem_req_valid && mem_req_ready;

    // Writes echo their data; reads sample the array before this edge's update.
    assign rsp_dat = mem_req_we ? mem_req_write : mem_q[idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (acc && mem_req_we) begin
            mem_q[idx] <= mem_req_write;
        end
    end

    lat_pipe #(
        .DEPTH (RD_LAT),
        .W     (MEM_DATA_W)
    ) u_pipe (
        .clk_i (clk),
        .clr_i (reset),
        .vld_i (acc),
        .dat_i (rsp_dat),
        .vld_o (mem_resp_valid),
        .dat_o (mem_resp_data)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (acc && !mem_resp_valid) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!acc && mem_resp_valid) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A response leaving this cycle frees a slot for a same-cycle accept.
    assign mem_req_ready = (cnt_q < CW'(MAX_OUT)) || mem_resp_valid;
    assign out_cnt_dbg   = cnt_q;

endmodule

// File: tb/tb_mem_lat_responder.sv
// Directed table-driven bench for mem_lat_responder.
// Three instances: default, MAX_OUT=2, and RD_LAT=1/MAX_OUT=1.
module tb_mem_lat_responder;

    logic clk;
    logic reset;

    logic        v   [3];
    logic        we  [3];
    logic [15:0] a   [3];
    logic [7:0]  wd  [3];

    logic       r0, rv0, r1, rv1, r2, rv2;
    logic [7:0] rd0, rd1, rd2;
    logic [2:0] c0;
    logic [1:0] c1;
    logic [0:0] c2;

    int total = 0;
    int pass  = 0;

    mem_lat_responder u0 (
        .clk(clk), .reset(reset),
        .mem_req_valid(v[0]), .mem_req_ready(r0),
        .mem_req_we(we[0]), .mem_req_addr(a[0]),
        .mem_req_write(wd[0]), .mem_resp_valid(rv0),
        .mem_resp_data(rd0), .out_cnt_dbg(c0)
    );

    mem_lat_responder #(.RD_LAT(4), .MAX_OUT(2)) u1 (
        .clk(clk), .reset(reset),
        .mem_req_valid(v[1]), .mem_req_ready(r1),
        .mem_req_we(we[1]), .mem_req_addr(a[1]),
        .mem_req_write(wd[1]), .mem_resp_valid(rv1),
        .mem_resp_data(rd1), .out_cnt_dbg(c1)
    );

    mem_lat_responder #(.RD_LAT(1), .MAX_OUT(1)) u2 (
        .clk(clk), .reset(reset),
        .mem_req_valid(v[2]), .mem_req_ready(r2),
        .mem_req_we(we[2]), .mem_req_addr(a[2]),
        .mem_req_write(wd[2]), .mem_resp_valid(rv2),
        .mem_resp_data(rd2), .out_cnt_dbg(c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        bit          v;
        bit          we;
        logic [15:0] a;
        logic [7:0]  wd;
        bit          rdy;
        bit          rv;
        logic [7:0]  rd;
        int          cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int d, bit vv, bit w, logic [15:0] ad,
                                logic [7:0] dd, bit rdy, bit rv,
                                logic [7:0] rd, int cnt);
        vec_t t;
        t = '{d, vv, w, ad, dd, rdy, rv, rd, cnt};
        return t;
    endfunction

    task automatic chk(string nm, int got, int exp);
        total++;
        if (got == exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic get(input int d, output int rdy, output int rv,
                       output int rd, output int cnt);
        case (d)
            0: begin rdy = int'(r0); rv = int'(rv0); rd = int'(rd0); cnt = int'(c0); end
            1: begin rdy = int'(r1); rv = int'(rv1); rd = int'(rd1); cnt = int'(c1); end
            default: begin rdy = int'(r2); rv = int'(rv2); rd = int'(rd2); cnt = int'(c2); end
        endcase
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0; we[i] = 1'b0; a[i] = '0; wd[i] = '0;
        end
    endtask

    // Drive one cycle of inputs just after the edge; sample mid-cycle.
    task automatic step(input int d, input bit vv, input bit w,
                        input logic [15:0] ad, input logic [7:0] dd);
        @(posedge clk);
        #1;
        idle_all();
        v[d] = vv; we[d] = w; a[d] = ad; wd[d] = dd;
        #3;
    endtask

    task automatic chk_all(string nm, int d, int e_rdy, int e_rv,
                           int e_rd, int e_cnt);
        int g_rdy, g_rv, g_rd, g_cnt;
        get(d, g_rdy, g_rv, g_rd, g_cnt);
        chk({nm, " ready"}, g_rdy, e_rdy);
        chk({nm, " rvalid"}, g_rv, e_rv);
        chk({nm, " rdata"}, g_rd, e_rd);
        chk({nm, " cnt"}, g_cnt, e_cnt);
    endtask

    initial begin
        int   k, rd_e, cnt_e, nacc;
        int   g_rdy, g_rv, g_rd, g_cnt;
        vec_t t;

        idle_all();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk_all($sformatf("reset d%0d", d), d, 1, 0, 0, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // write then read-after-write
        tbl.push_back(mk(0, 1, 1, 16'h0010, 8'hA5, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0010, 8'h00, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h00, 2));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h00, 2));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 1, 1, 8'hA5, 2));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 1, 1, 8'hA5, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 1, 0, 8'hA5, 0));

        // 8 writes, 8 back-to-back reads, drain
        for (k = 0; k < 21; k++) begin
            if (k < 4)       rd_e = 'hA5;
            else if (k < 20) rd_e = 'h30 + ((k - 4) % 8);
            else             rd_e = 'h37;
            cnt_e = (k < 16 ? k : 16) - (k < 4 ? 0 : (k - 4 < 16 ? k - 4 : 16));
            tbl.push_back(mk(0, k < 16, k < 8, 16'(k % 8), 8'(8'h30 + k),
                             1, (k >= 4 && k <= 19), 8'(rd_e), cnt_e));
        end

        // address wrap: 0x1FF aliases 0x0FF
        tbl.push_back(mk(0, 1, 1, 16'h01FF, 8'h5C, 1, 0, 8'h37, 0));
        tbl.push_back(mk(0, 1, 0, 16'h00FF, 8'h00, 1, 0, 8'h37, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h37, 2));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h37, 2));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 1, 1, 8'h5C, 2));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 1, 1, 8'h5C, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h5C, 0));

        // RD_LAT=1: response right after accept, cnt steady on overlap
        tbl.push_back(mk(2, 1, 1, 16'h0003, 8'h77, 1, 0, 8'h00, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0003, 8'h00, 1, 1, 8'h77, 1));
        tbl.push_back(mk(2, 1, 0, 16'h0004, 8'h00, 1, 1, 8'h77, 1));
        tbl.push_back(mk(2, 0, 0, 16'h0000, 8'h00, 1, 1, 8'h00, 1));
        tbl.push_back(mk(2, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h00, 0));

        foreach (tbl[i]) begin
            t = tbl[i];
            step(t.d, t.v, t.we, t.a, t.wd);
            chk_all($sformatf("row%0d", i), t.d, int'(t.rdy), int'(t.rv),
                    int'(t.rd), t.cnt);
        end

        // MAX_OUT=2 throttling with valid held high
        nacc = 0;
        for (int c = 0; c < 12; c++) begin
            step(1, 1, 0, 16'h0000, 8'h00);
            get(1, g_rdy, g_rv, g_rd, g_cnt);
            chk($sformatf("thr%0d ready", c), g_rdy, (c % 4) < 2);
            chk($sformatf("thr%0d rvalid", c), g_rv, c >= 4 && (c % 4) < 2);
            chk($sformatf("thr%0d cnt", c), g_cnt, c < 2 ? c : 2);
            nacc += g_rdy;
        end
        step(1, 0, 0, 16'h0000, 8'h00);
        chk("thr accepts", nacc, 6);

        // reset with three reads in flight
        step(0, 1, 0, 16'h0010, 8'h00);
        step(0, 1, 0, 16'h0005, 8'h00);
        step(0, 1, 0, 16'h00FF, 8'h00);
        @(posedge clk);
        #1;
        idle_all();
        reset = 1'b1;
        #3;
        chk_all("rst mid", 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step(0, 0, 0, 16'h0000, 8'h00);
            get(0, g_rdy, g_rv, g_rd, g_cnt);
            chk($sformatf("post rst%0d rvalid", c), g_rv, 0);
            chk($sformatf("post rst%0d cnt", c), g_cnt, 0);
        end
        step(0, 1, 0, 16'h0010, 8'h00);
        step(0, 1, 0, 16'h0005, 8'h00);
        step(0, 0, 0, 16'h0000, 8'h00);
        step(0, 0, 0, 16'h0000, 8'h00);
        step(0, 0, 0, 16'h0000, 8'h00);
        chk_all("cleared 0x10", 0, 1, 1, 0, 2);
        step(0, 0, 0, 16'h0000, 8'h00);
        chk_all("cleared 0x05", 0, 1, 1, 0, 1);
        step(0, 0, 0, 16'h0000, 8'h00);
        chk_all("drained", 0, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
